// File: rtl/calc1_pkg.sv
// Shared calc1 command/response encodings, requester FSM states and response payload.
package calc1_pkg;

   localparam int unsigned CMD_W  = 4;
   localparam int unsigned DATA_W = 32;
   localparam int unsigned RSP_W  = 2;
   localparam int unsigned TMR_W  = 8;

   localparam logic [CMD_W-1:0] CMD_NOP = 4'd0;
   localparam logic [CMD_W-1:0] CMD_ADD = 4'd1;
   localparam logic [CMD_W-1:0] CMD_SUB = 4'd2;
   localparam logic [CMD_W-1:0] CMD_SHL = 4'd5;
   localparam logic [CMD_W-1:0] CMD_SHR = 4'd6;

   localparam logic [RSP_W-1:0] RSP_NONE = 2'd0;
   localparam logic [RSP_W-1:0] RSP_OK   = 2'd1;
   localparam logic [RSP_W-1:0] RSP_ERR  = 2'd2;
   localparam logic [RSP_W-1:0] RSP_TMO  = 2'd3;

   typedef enum logic [2:0] {
      IDLE,
      SEND_A,
      SEND_B,
      WAIT,
      DONE
   } calc1_state_t;

   typedef struct packed {
      logic [RSP_W-1:0]  code;
      logic [DATA_W-1:0] data;
   } calc1_rsp_t;

   // True for the commands calc1 actually implements.
   function automatic logic cmd_is_legal(input logic [CMD_W-1:0] cmd);
      return (cmd == CMD_ADD) || (cmd == CMD_SUB) || (cmd == CMD_SHL) || (cmd == CMD_SHR);
   endfunction

endpackage

// File: rtl/calc1_req_timer.sv
// WAIT-phase timeout counter: cleared on WAIT entry, counts WAIT cycles, flags the last allowed one.
module calc1_req_timer
   import calc1_pkg::*;
#(
   parameter int unsigned TIMEOUT_CYCLES = 64
) (
   input  logic c_clk,
   input  logic reset,
   input  logic clear,
   input  logic enable,
   output logic expire_c
);

   logic [TMR_W-1:0] count_q;

   always_ff @(posedge c_clk) begin
      if (reset) begin
         count_q <= '0;
      end else if (clear) begin
         count_q <= '0;
      end else if (enable) begin
         count_q <= count_q + TMR_W'(1);
      end
   end

   // count_q holds the number of completed WAIT cycles, so this marks WAIT cycle TIMEOUT_CYCLES.
   assign expire_c = enable && (count_q == TMR_W'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/calc1_requester.sv
// Host-side requester for one calc1 port: sends cmd/a then b, waits for a response or timeout.
// Optional build macro CALC1_REQ_CMD_CHECK_EN rejects unsupported commands locally.
module calc1_requester
   import calc1_pkg::*;
#(
   parameter int unsigned TIMEOUT_CYCLES = 64
) (
   input  logic              c_clk,
   input  logic              reset,
   input  logic              op_valid,
   output logic              op_ready,
   input  logic [CMD_W-1:0]  op_cmd,
   input  logic [DATA_W-1:0] op_a,
   input  logic [DATA_W-1:0] op_b,
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic [RSP_W-1:0]  rsp_code,
   output logic [DATA_W-1:0] rsp_data,
   output logic [0:3]        req_cmd_out,
   output logic [0:31]       req_data_out,
   input  logic [0:1]        out_resp,
   input  logic [0:31]       out_data
);

   calc1_state_t      state, state_nx;
   calc1_rsp_t        rsp_q, rsp_nx;
   logic              op_ready_nx;
   logic              rsp_valid_nx;
   logic [CMD_W-1:0]  req_cmd_nx;
   logic [DATA_W-1:0] req_data_nx;
   logic [DATA_W-1:0] b_q;
   logic              lat_en;
   logic              tmr_clear;
   logic              tmr_en;
   logic              expire_c;
   logic              cmd_ok_c;

`ifdef CALC1_REQ_CMD_CHECK_EN
   assign cmd_ok_c = cmd_is_legal(op_cmd);
`else
   assign cmd_ok_c = 1'b1;
`endif

   calc1_req_timer #(
      .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
   ) u_timer (
      .c_clk    (c_clk),
      .reset    (reset),
      .clear    (tmr_clear),
      .enable   (tmr_en),
      .expire_c (expire_c)
   );

   // State and registered outputs.
   always_ff @(posedge c_clk) begin
      if (reset) begin
         state        <= IDLE;
         op_ready     <= 1'b0;
         rsp_valid    <= 1'b0;
         rsp_q        <= '0;
         req_cmd_out  <= '0;
         req_data_out <= '0;
         b_q          <= '0;
      end else begin
         state        <= state_nx;
         op_ready     <= op_ready_nx;
         rsp_valid    <= rsp_valid_nx;
         rsp_q        <= rsp_nx;
         req_cmd_out  <= req_cmd_nx;
         req_data_out <= req_data_nx;
         if (lat_en) begin
            b_q <= op_b;
         end
      end
   end

   // Next state and next register values; request port idles at zero.
   always_comb begin
      state_nx     = state;
      op_ready_nx  = 1'b0;
      rsp_valid_nx = rsp_valid;
      rsp_nx       = rsp_q;
      req_cmd_nx   = CMD_NOP;
      req_data_nx  = '0;
      lat_en       = 1'b0;
      tmr_clear    = 1'b0;
      tmr_en       = 1'b0;

      case (state)
         IDLE: begin
            if (op_valid && op_ready) begin
               lat_en = 1'b1;
               if (cmd_ok_c) begin
                  state_nx    = SEND_A;
                  req_cmd_nx  = op_cmd;
                  req_data_nx = op_a;
               end else begin
                  state_nx     = DONE;
                  rsp_valid_nx = 1'b1;
                  rsp_nx.code  = RSP_TMO;
                  rsp_nx.data  = '0;
               end
            end else begin
               op_ready_nx = 1'b1;
            end
         end

         SEND_A: begin
            state_nx    = SEND_B;
            req_data_nx = b_q;
         end

         SEND_B: begin
            state_nx  = WAIT;
            tmr_clear = 1'b1;
         end

         WAIT: begin
            tmr_en = 1'b1;
            // A real response in the expiring cycle takes priority over the timeout.
            if (out_resp != RSP_NONE) begin
               state_nx     = DONE;
               rsp_valid_nx = 1'b1;
               rsp_nx.code  = out_resp;
               rsp_nx.data  = (out_resp == RSP_OK) ? out_data : '0;
            end else if (expire_c) begin
               state_nx     = DONE;
               rsp_valid_nx = 1'b1;
               rsp_nx.code  = RSP_TMO;
               rsp_nx.data  = '0;
            end
         end

         DONE: begin
            if (rsp_valid && rsp_ready) begin
               state_nx     = IDLE;
               op_ready_nx  = 1'b1;
               rsp_valid_nx = 1'b0;
               rsp_nx       = '0;
            end
         end

         default: begin
            state_nx = IDLE;
         end
      endcase
   end

   assign rsp_code = rsp_q.code;
   assign rsp_data = rsp_q.data;

endmodule

// File: tb/tb_calc1_requester.sv
// Scoreboard bench for calc1_requester: directed ops with a hand-driven calc1 responder.
module tb_calc1_requester;
   import calc1_pkg::*;

   localparam int unsigned TMO = 64;

   logic        c_clk = 1'b0;
   logic        reset = 1'b1;
   logic        op_valid = 1'b0;
   logic        op_ready;
   logic [3:0]  op_cmd = '0;
   logic [31:0] op_a = '0;
   logic [31:0] op_b = '0;
   logic        rsp_valid;
   logic        rsp_ready = 1'b0;
   logic [1:0]  rsp_code;
   logic [31:0] rsp_data;
   logic [0:3]  req_cmd_out;
   logic [0:31] req_data_out;
   logic [0:1]  out_resp = '0;
   logic [0:31] out_data = '0;

   int n_tests = 0;
   int n_fail  = 0;

   logic [33:0] sb_q[$];
   string       sb_name[$];
   logic [33:0] mon_exp;
   string       mon_nm;

   always #5 c_clk = ~c_clk;

   calc1_requester #(
      .TIMEOUT_CYCLES(TMO)
   ) dut (
      .c_clk        (c_clk),
      .reset        (reset),
      .op_valid     (op_valid),
      .op_ready     (op_ready),
      .op_cmd       (op_cmd),
      .op_a         (op_a),
      .op_b         (op_b),
      .rsp_valid    (rsp_valid),
      .rsp_ready    (rsp_ready),
      .rsp_code     (rsp_code),
      .rsp_data     (rsp_data),
      .req_cmd_out  (req_cmd_out),
      .req_data_out (req_data_out),
      .out_resp     (out_resp),
      .out_data     (out_data)
   );

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
      n_tests++;
      if (act !== exp_v) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp_v);
      end
   endtask

   task automatic tick();
      @(posedge c_clk);
      #1;
   endtask

   // Monitor: compare each consumed response against the scoreboard head.
   always @(negedge c_clk) begin
      if (!reset && rsp_valid && rsp_ready) begin
         if (sb_q.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL unexpected_rsp: got code %0d data 0x%0h, expected no response", rsp_code, rsp_data);
         end else begin
            mon_exp = sb_q.pop_front();
            mon_nm  = sb_name.pop_front();
            check({mon_nm, "_code"}, 32'(rsp_code), 32'(mon_exp[33:32]));
            check({mon_nm, "_data"}, rsp_data, mon_exp[31:0]);
         end
      end
   end

   // One full operation. dly = WAIT cycle (1-based) in which calc1 answers, 0 = never.
   task automatic run_op(input string name, input logic [3:0] cmd, input logic [31:0] a,
                         input logic [31:0] b, input int dly, input logic [1:0] resp,
                         input logic [31:0] rdata, input logic [1:0] exp_code,
                         input logic [31:0] exp_data, input int hold, input bit early);
      int guard = 0;
      while (!op_ready && guard < 20) begin
         tick();
         guard++;
      end
      check({name, "_op_ready"}, 32'(op_ready), 32'd1);
      sb_q.push_back({exp_code, exp_data});
      sb_name.push_back(name);
      op_valid = 1'b1;
      op_cmd   = cmd;
      op_a     = a;
      op_b     = b;
      tick();
      op_valid = 1'b0;
      op_cmd   = '0;
      op_a     = '0;
      op_b     = '0;
      if (early) begin
         out_resp = RSP_OK;
         out_data = 32'hBAD0_0001;
      end
      check({name, "_t1_cmd"}, 32'(req_cmd_out), 32'(cmd));
      check({name, "_t1_data"}, 32'(req_data_out), a);
      check({name, "_t1_busy"}, 32'(op_ready), 32'd0);
      tick();
      check({name, "_t2_cmd"}, 32'(req_cmd_out), 32'd0);
      check({name, "_t2_data"}, 32'(req_data_out), b);
      out_resp = '0;
      out_data = '0;
      tick();
      check({name, "_wait_data"}, 32'(req_data_out), 32'd0);
      if (dly == 0) begin
         repeat (TMO - 1) tick();
         check({name, "_pre_tmo"}, 32'(rsp_valid), 32'd0);
         tick();
      end else begin
         repeat (dly - 1) tick();
         out_resp = resp;
         out_data = rdata;
         tick();
         out_resp = '0;
         out_data = '0;
      end
      check({name, "_rsp_latency"}, 32'(rsp_valid), 32'd1);
      for (int i = 0; i < hold; i++) begin
         tick();
         check({name, "_hold_valid"}, 32'(rsp_valid), 32'd1);
         check({name, "_hold_code"}, 32'(rsp_code), 32'(exp_code));
         check({name, "_hold_data"}, rsp_data, exp_data);
      end
      rsp_ready = 1'b1;
      tick();
      rsp_ready = 1'b0;
      check({name, "_consumed"}, 32'(rsp_valid), 32'd0);
      check({name, "_back_idle"}, 32'(op_ready), 32'd1);
   endtask

   initial begin
      // Reset values.
      repeat (3) tick();
      check("rst_op_ready", 32'(op_ready), 32'd0);
      check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
      check("rst_rsp_code", 32'(rsp_code), 32'd0);
      check("rst_rsp_data", rsp_data, 32'd0);
      check("rst_req_cmd", 32'(req_cmd_out), 32'd0);
      check("rst_req_data", 32'(req_data_out), 32'd0);
      reset = 1'b0;
      tick();
      check("rst_first_idle", 32'(op_ready), 32'd1);

      run_op("add_ok",   CMD_ADD, 32'h0000_0001, 32'h1FFF_FFFF, 1, RSP_OK,  32'h2000_0000, RSP_OK,  32'h2000_0000, 0, 1'b0);
      run_op("add_err",  CMD_ADD, 32'hFFFF_FFFF, 32'h0000_0001, 2, RSP_ERR, 32'hDEAD_BEEF, RSP_ERR, 32'h0, 0, 1'b0);
      run_op("sub_hold", CMD_SUB, 32'h0000_0001, 32'h0000_000F, 1, RSP_ERR, 32'h1234_5678, RSP_ERR, 32'h0, 5, 1'b0);
      run_op("shl_early", CMD_SHL, 32'h0000_0003, 32'h0000_0004, 3, RSP_OK, 32'h0000_0030, RSP_OK, 32'h0000_0030, 0, 1'b1);
      run_op("shr_tmo",  CMD_SHR, 32'h0000_0080, 32'h0000_0004, 0, RSP_NONE, 32'h0, RSP_TMO, 32'h0, 0, 1'b0);
      run_op("add_last", CMD_ADD, 32'h0000_1000, 32'h0000_0234, int'(TMO), RSP_OK, 32'h0000_1234, RSP_OK, 32'h0000_1234, 0, 1'b0);

      // Reset in the middle of WAIT drops the operation silently.
      op_valid = 1'b1;
      op_cmd   = CMD_ADD;
      op_a     = 32'h5;
      op_b     = 32'h6;
      tick();
      op_valid = 1'b0;
      repeat (4) tick();
      reset = 1'b1;
      tick();
      check("midrst_op_ready", 32'(op_ready), 32'd0);
      check("midrst_rsp_valid", 32'(rsp_valid), 32'd0);
      check("midrst_req_cmd", 32'(req_cmd_out), 32'd0);
      reset    = 1'b0;
      out_resp = RSP_OK;
      out_data = 32'h77;
      tick();
      check("midrst_ready_after", 32'(op_ready), 32'd1);
      for (int i = 0; i < 3; i++) begin
         check("midrst_no_rsp", 32'(rsp_valid), 32'd0);
         tick();
      end
      out_resp = '0;
      out_data = '0;

`ifdef CALC1_REQ_CMD_CHECK_EN
      check("cmd3_ready", 32'(op_ready), 32'd1);
      sb_q.push_back({RSP_TMO, 32'h0});
      sb_name.push_back("cmd3_reject");
      op_valid = 1'b1;
      op_cmd   = 4'd3;
      op_a     = 32'h10;
      op_b     = 32'h20;
      tick();
      op_valid = 1'b0;
      op_cmd   = '0;
      check("cmd3_req_cmd", 32'(req_cmd_out), 32'd0);
      check("cmd3_rsp_t1", 32'(rsp_valid), 32'd1);
      rsp_ready = 1'b1;
      tick();
      rsp_ready = 1'b0;
      check("cmd3_consumed", 32'(rsp_valid), 32'd0);
`else
      run_op("cmd3_issue", 4'd3, 32'h10, 32'h20, 2, RSP_ERR, 32'hFFFF, RSP_ERR, 32'h0, 0, 1'b0);
`endif

      run_op("shr_after", CMD_SHR, 32'h0000_0080, 32'h0000_0004, 1, RSP_OK, 32'h0000_0008, RSP_OK, 32'h0000_0008, 0, 1'b0);

      repeat (2) tick();
      check("sb_drained", 32'(sb_q.size()), 32'd0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation still running at %0t, expected completion", $time);
      $fatal(1);
   end

endmodule

// File: doc/calc1_requester.md
CALC1_REQUESTER -- requirements
Module: calc1_requester

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 64: WAIT cycles allowed before a timeout response; legal range 2..255.
REQ-002 c_clk  input  1  sole clock; all state updates on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 op_valid  input  1  host presents an operation.
REQ-005 op_ready  output  1  block accepts an operation this cycle.
REQ-006 op_cmd  input  4  calc1 command: 1 add, 2 sub, 5 shl, 6 shr.
REQ-007 op_a  input  32  operand 1.
REQ-008 op_b  input  32  operand 2.
REQ-009 rsp_valid  output  1  result available.
REQ-010 rsp_ready  input  1  host consumes the result.
REQ-011 rsp_code  output  2  1 success, 2 calc1 error, 3 local timeout or reject.
REQ-012 rsp_data  output  32  result data; zero when rsp_code is not 1.
REQ-013 req_cmd_out  output  [0:3]  command to calc1 request port.
REQ-014 req_data_out  output  [0:31]  data to calc1 request port.
REQ-015 out_resp  input  [0:1]  calc1 response for this port.
REQ-016 out_data  input  [0:31]  calc1 result for this port.

Function
REQ-017 FSM states: IDLE, SEND_A, SEND_B, WAIT, DONE; all DUV-side outputs are registered.
REQ-018 op_ready shall be 1 only in IDLE; handshake op_valid&&op_ready in cycle T latches cmd/a/b and moves to SEND_A.
REQ-019 Cycle T+1 (SEND_A): req_cmd_out=op_cmd, req_data_out=op_a.
REQ-020 Cycle T+2 (SEND_B): req_cmd_out=0, req_data_out=op_b.
REQ-021 From T+3 (WAIT): req_cmd_out=0, req_data_out=0; 8-bit timeout counter cleared on WAIT entry, incremented each WAIT cycle.
REQ-022 First WAIT cycle with out_resp!=0: capture out_resp into rsp_code, out_data into rsp_data (zero if out_resp!=1), go DONE.
REQ-023 Counter reaching TIMEOUT_CYCLES with out_resp==0: rsp_code=3, rsp_data=0, go DONE; a nonzero out_resp in that same cycle wins over timeout.
REQ-024 DONE: rsp_valid=1, rsp_code/rsp_data stable until rsp_valid&&rsp_ready, then IDLE; no new op accepted before return to IDLE.
REQ-025 out_resp!=0 in any state other than WAIT shall be ignored.
REQ-026 Back-to-back throughput: one operation per (4 + response latency) cycles minimum.

Reset
REQ-027 reset=1 at a clock edge forces IDLE regardless of state, including mid-SEND or WAIT; the in-flight operation is dropped with no response.
REQ-028 Reset values: op_ready=0 during reset (1 in first IDLE cycle after), rsp_valid=0, rsp_code=0, rsp_data=0, req_cmd_out=0, req_data_out=0, counter=0.

Configuration
REQ-029 Macro CALC1_REQ_CMD_CHECK_EN defined: op_cmd not in {1,2,5,6} is not issued to calc1; the block goes IDLE->DONE directly with rsp_code=3, rsp_data=0, rsp_valid in cycle T+1.
REQ-030 Macro undefined: every accepted op_cmd is issued unchanged, and calc1 produces the response.

Structure
REQ-031 Shared package calc1_pkg: command constants (CMD_NOP=0, CMD_ADD=1, CMD_SUB=2, CMD_SHL=5, CMD_SHR=6), response constants (RSP_NONE=0, RSP_OK=1, RSP_ERR=2, RSP_TMO=3), FSM state enum.
REQ-032 One sub-module, calc1_req_timer: timeout counter with clear/enable/expire; FSM and datapath stay in calc1_requester.

Verification
REQ-033 add a=0x00000001, b=0x1FFFFFFF, DUV responds 1/0x20000000 -> cmd 1/0x1 at T+1, 0/0x1FFFFFFF at T+2; rsp_code=1, rsp_data=0x20000000.
REQ-034 add a=0xFFFFFFFF, b=0x1, DUV responds 2 -> rsp_code=2, rsp_data=0.
REQ-035 sub a=0x1, b=0xF, DUV responds 2 -> rsp_code=2; rsp_valid held 5 cycles with rsp_ready=0, data stable.
REQ-036 out_resp held 0 -> rsp_code=3 exactly TIMEOUT_CYCLES (64) cycles after WAIT entry; resp=1 on cycle 64 -> rsp_code=1.
REQ-037 reset pulsed during WAIT, then DUV resp=1 -> no rsp_valid; op_ready=1 after reset deasserts.
REQ-038 op_cmd=3 with CALC1_REQ_CMD_CHECK_EN -> req_cmd_out stays 0, rsp_code=3 at T+1; without it -> cmd 3 driven at T+1.
